// File: rtl/demux_pkg.sv
// Shared definitions for the demux event counter: FSM encodings, default
// counter width and the classifier for the registered demux lines.
package demux_pkg;

  localparam int DEF_CNT_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_ONEHOT,
    CLS_MULTI
  } y_class_e;

  function automatic y_class_e classify(input logic [3:0] v);
    case ($countones(v))
      0:       return CLS_ZERO;
      1:       return CLS_ONEHOT;
      default: return CLS_MULTI;
    endcase
  endfunction

endpackage

// File: rtl/demux_event_counter_sat_counter.sv
// Saturating per-channel event counter with synchronous clear and freeze.
module sat_counter
  import demux_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             freeze,
  output logic [CNT_W-1:0] cnt
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !freeze && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/demux_event_counter.sv
// Counts one-hot events on four demux output lines, flags non-one-hot samples.
// Optional macro DEMUX_EVENT_EDGE_EN counts only 0->1 transitions per channel.
module demux_event_counter
  import demux_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y1,
  input  logic             y2,
  input  logic             y3,
  input  logic             y4,
  input  logic             clr,
  input  logic             rd_en,
  input  logic [1:0]       rd_sel,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_valid,
  output logic             err,
  output logic [1:0]       state
);

  // Bit i of y_q belongs to channel i (y1 is channel 0).
  logic [3:0]       y_q;
  logic [3:0]       ev;
  logic             freeze;
  y_class_e         y_cls;
  logic [CNT_W-1:0] cnt [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) y_q <= '0;
    else     y_q <= {y4, y3, y2, y1};
  end

`ifdef DEMUX_EVENT_EDGE_EN
  logic [3:0] y_qq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) y_qq <= '0;
    else     y_qq <= y_q;
  end
`endif

  assign y_cls  = classify(y_q);
  assign freeze = (state == ST_FAULT);

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    ev = '0;
    if (y_cls == CLS_ONEHOT) begin
`ifdef DEMUX_EVENT_EDGE_EN
      ev = y_q & ~y_qq;
`else
      ev = y_q;
`endif
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_ch
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .inc    (ev[i]),
      .freeze (freeze),
      .cnt    (cnt[i])
    );
  end

  // clr wins over any simultaneous event or fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      err   <= 1'b0;
    end else if (clr) begin
      state <= ST_IDLE;
      err   <= 1'b0;
    end else begin
      if (y_cls == CLS_MULTI) err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (y_cls == CLS_MULTI) state <= ST_FAULT;
          else if (|ev)           state <= ST_RUN;
        end
        ST_RUN: begin
          if (y_cls == CLS_MULTI) state <= ST_FAULT;
        end
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Reads capture the pre-edge counter value, so they see pre-increment and
  // pre-clear contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_out   <= '0;
      cnt_valid <= 1'b0;
    end else begin
      cnt_valid <= rd_en;
      if (rd_en) cnt_out <= cnt[rd_sel];
    end
  end

endmodule

// File: tb/tb_demux_event_counter.sv
// Directed self-checking bench for demux_event_counter (CNT_W = 8).
module tb_demux_event_counter;

`ifdef DEMUX_EVENT_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       y1 = 1'b0, y2 = 1'b0, y3 = 1'b0, y4 = 1'b0;
  logic       clr = 1'b0;
  logic       rd_en = 1'b0;
  logic [1:0] rd_sel = 2'd0;
  logic [7:0] cnt_out;
  logic       cnt_valid;
  logic       err;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;

  demux_event_counter #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .y4        (y4),
    .clr       (clr),
    .rd_en     (rd_en),
    .rd_sel    (rd_sel),
    .cnt_out   (cnt_out),
    .cnt_valid (cnt_valid),
    .err       (err),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Bits written in y1 y2 y3 y4 order, matching the "1000" style vectors.
  task automatic set_y(input logic [3:0] v);
    {y1, y2, y3, y4} = v;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_read(input logic [1:0] sel, input logic [31:0] exp, input string tag);
    rd_sel = sel;
    rd_en  = 1'b1;
    @(negedge clk);
    rd_en  = 1'b0;
    check({tag, "_valid"}, cnt_valid, 1);
    check(tag, cnt_out, exp);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    // Reset state
    #3 rst = 1'b1;
    #1;
    check("rst_cnt_out", cnt_out, 0);
    check("rst_valid", cnt_valid, 0);
    check("rst_err", err, 0);
    check("rst_state", state, 0);
    cycles(2);
    rst = 1'b0;
    cycles(1);

    // Channel 0 held five cycles, then read
    set_y(4'b1000);
    cycles(5);
    set_y(4'b0000);
    cycles(1);
    do_read(2'd0, EDGE ? 1 : 5, "ch0_count");
    check("ch0_state_run", state, 1);
    cycles(1);
    check("valid_drops", cnt_valid, 0);
    check("cnt_out_holds", cnt_out, EDGE ? 1 : 5);

    // Channel 2 saturation
    set_y(4'b0010);
    cycles(300);
    set_y(4'b0000);
    cycles(1);
    do_read(2'd2, EDGE ? 1 : 255, "ch2_saturate");
    do_read(2'd0, EDGE ? 1 : 5, "ch0_untouched");

    // Multi-hot sample forces FAULT and freezes counters
    pulse_clr();
    set_y(4'b0100);
    cycles(3);
    set_y(4'b0110);
    cycles(1);
    set_y(4'b0100);
    cycles(4);
    set_y(4'b0000);
    cycles(1);
    check("fault_err", err, 1);
    check("fault_state", state, 2);
    do_read(2'd1, EDGE ? 1 : 3, "fault_ch1_frozen");
    do_read(2'd2, 0, "fault_ch2_frozen");

    // clr leaves FAULT and zeroes everything
    pulse_clr();
    check("clr_err", err, 0);
    check("clr_state", state, 0);
    do_read(2'd0, 0, "clr_ch0");
    do_read(2'd1, 0, "clr_ch1");
    do_read(2'd2, 0, "clr_ch2");
    do_read(2'd3, 0, "clr_ch3");

    // Read coinciding with an increment returns the pre-increment value
    set_y(4'b0001);
    cycles(8);
    do_read(2'd3, EDGE ? 1 : 7, "pre_inc_read");
    do_read(2'd3, EDGE ? 1 : 8, "next_read");

    // Asynchronous reset mid-read during RUN
    check("run_before_rst", state, 1);
    rd_sel = 2'd3;
    rd_en  = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", cnt_valid, 0);
    check("arst_cnt_out", cnt_out, 0);
    check("arst_err", err, 0);
    check("arst_state", state, 0);
    rd_en = 1'b0;
    set_y(4'b0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_no_valid", cnt_valid, 0);
    do_read(2'd3, 0, "arst_ch3_zero");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
